// File: rtl/jp_responder_pkg.sv
// ---------------------------------------------------------------------------
// jp_responder_pkg : button indices, FSM states and constants for jp_responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jp_responder_pkg;

  localparam int JP_NUM_BTNS  = 8;
  localparam int JP_BTN_A      = 0;
  localparam int JP_BTN_B      = 1;
  localparam int JP_BTN_SELECT = 2;
  localparam int JP_BTN_START  = 3;
  localparam int JP_BTN_UP     = 4;
  localparam int JP_BTN_DOWN   = 5;
  localparam int JP_BTN_LEFT   = 6;
  localparam int JP_BTN_RIGHT  = 7;

  localparam logic [3:0] JP_BIT_CNT_MAX = 4'd8;

  typedef enum logic [1:0] {
    JP_ST_LOAD  = 2'd0,
    JP_ST_SHIFT = 2'd1,
    JP_ST_DONE  = 2'd2
  } jp_state_e;

endpackage

`default_nettype wire

// File: rtl/jp_responder_sync_filter.sv
// ---------------------------------------------------------------------------
// jp_responder_sync_filter : synchroniser + deglitch filter + change pulse
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jp_responder_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level_out,
  output logic edge_out
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // Counter only advances while the synchronised sample disagrees with the
  // filtered level; any agreeing sample restarts the qualification window.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    level_d = level_q;
    cnt_d   = '0;
    if (sample != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    edge_d = level_d ^ level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      edge_q  <= edge_d;
    end
  end

  assign level_out = level_q;
  assign edge_out  = edge_q;

endmodule

`default_nettype wire

// File: rtl/jp_responder.sv
// ---------------------------------------------------------------------------
// jp_responder : NES joypad (CD4021) emulator answering console latch/clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jp_responder
  import jp_responder_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int FILTER_CYCLES     = 4,
  parameter int TURBO_HALF_PERIOD = 3333333
) (
  input  logic       clk_in,
  input  logic       nres_in,
  input  logic [7:0] btn_in,
  input  logic [1:0] turbo_en_in,
  input  logic       jp_latch_in,
  input  logic       jp_clk_in,
  output logic       jp_data_out,
  output logic       poll_strobe_out,
  output logic [3:0] bit_cnt_out
);

  localparam int TW = (TURBO_HALF_PERIOD > 1) ? $clog2(TURBO_HALF_PERIOD) : 1;
  localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_HALF_PERIOD - 1);

  // Reset asserts asynchronously but is released through two flops.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1] & nres_in;

  logic latch_lvl, latch_chg, clk_lvl, clk_chg;
  logic latch_fall, clk_rise;

  jp_responder_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_latch_filt (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .async_in (jp_latch_in),
    .level_out(latch_lvl),
    .edge_out (latch_chg)
  );

  jp_responder_sync_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filt (
    .clk      (clk_in),
    .rst_n    (rst_n),
    .async_in (jp_clk_in),
    .level_out(clk_lvl),
    .edge_out (clk_chg)
  );

  assign latch_fall = latch_chg & ~latch_lvl;
  assign clk_rise   = clk_chg & clk_lvl;

  logic [TW-1:0] turbo_cnt_q, turbo_cnt_d;
  logic          turbo_phase_q, turbo_phase_d;
  logic [7:0]    eff;

  always_comb begin
    turbo_cnt_d   = turbo_cnt_q + TW'(1);
    turbo_phase_d = turbo_phase_q;
    if (turbo_cnt_q == TURBO_LAST) begin
      turbo_cnt_d   = '0;
      turbo_phase_d = ~turbo_phase_q;
    end
    eff           = btn_in;
    eff[JP_BTN_A] = btn_in[JP_BTN_A] & (~turbo_en_in[0] | turbo_phase_q);
    eff[JP_BTN_B] = btn_in[JP_BTN_B] & (~turbo_en_in[1] | turbo_phase_q);
  end

  jp_state_e  state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       strobe_q, strobe_d;
  logic       data_q, data_d;

  // A high latch overrides every other event, so a coincident clock edge
  // is simply lost; the same holds for the clock edge on the latch fall.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = 1'b0;
    if (latch_lvl) begin
      state_d   = JP_ST_LOAD;
      sr_d      = eff;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        JP_ST_LOAD: begin
          if (latch_fall) begin
            strobe_d = 1'b1;
            state_d  = JP_ST_SHIFT;
          end
        end
        JP_ST_SHIFT: begin
          if (clk_rise) begin
            sr_d      = {1'b1, sr_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == JP_BIT_CNT_MAX - 4'd1) state_d = JP_ST_DONE;
          end
        end
        JP_ST_DONE: begin
          if (clk_rise) sr_d = {1'b1, sr_q[7:1]};
        end
        default: state_d = JP_ST_SHIFT;
      endcase
    end
    data_d = ~sr_d[0];
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      turbo_cnt_q   <= '0;
      turbo_phase_q <= 1'b1;
      state_q       <= JP_ST_SHIFT;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      strobe_q      <= 1'b0;
      data_q        <= 1'b1;
    end else begin
      turbo_cnt_q   <= turbo_cnt_d;
      turbo_phase_q <= turbo_phase_d;
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      strobe_q      <= strobe_d;
      data_q        <= data_d;
    end
  end

  assign jp_data_out     = data_q;
  assign poll_strobe_out = strobe_q;
  assign bit_cnt_out     = bit_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_jp_responder.sv
// ---------------------------------------------------------------------------
// tb_jp_responder : table-driven, scoreboarded bench for jp_responder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jp_responder;

  logic       clk_in = 1'b0;
  logic       nres_in;
  logic [7:0] btn_in;
  logic [1:0] turbo_en_in;
  logic       jp_latch_in;
  logic       jp_clk_in;
  logic       jp_data_out;
  logic       poll_strobe_out;
  logic [3:0] bit_cnt_out;

  jp_responder #(
    .SYNC_STAGES      (2),
    .FILTER_CYCLES    (4),
    .TURBO_HALF_PERIOD(10)
  ) dut (
    .clk_in         (clk_in),
    .nres_in        (nres_in),
    .btn_in         (btn_in),
    .turbo_en_in    (turbo_en_in),
    .jp_latch_in    (jp_latch_in),
    .jp_clk_in      (jp_clk_in),
    .jp_data_out    (jp_data_out),
    .poll_strobe_out(poll_strobe_out),
    .bit_cnt_out    (bit_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] btn;
    logic [7:0] exp_line;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  logic exp_q[$];

  always @(negedge clk_in) if (poll_strobe_out === 1'b1) strobe_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic poll_load(input logic [7:0] btn);
    btn_in      = btn;
    jp_latch_in = 1'b1;
    cycles(12);
    jp_latch_in = 1'b0;
    cycles(12);
  endtask

  task automatic pulse();
    jp_clk_in = 1'b1;
    cycles(20);
    jp_clk_in = 1'b0;
    cycles(20);
  endtask

  task automatic run_vector(input logic [7:0] btn, input logic [7:0] exp_line);
    int   s0;
    logic e;
    s0 = strobe_cnt;
    poll_load(btn);
    check("strobe_per_poll", strobe_cnt - s0, 1);
    check("bitcnt_after_load", {28'd0, bit_cnt_out}, 0);
    for (int i = 0; i < 8; i++) exp_q.push_back(exp_line[i]);
    for (int i = 0; i < 3; i++) exp_q.push_back(1'b0);
    for (int k = 0; k <= 10; k++) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 0, 1);
        e = 1'b0;
      end else begin
        e = exp_q.pop_front();
      end
      check($sformatf("line_btn%0h_bit%0d", btn, k), {31'd0, jp_data_out}, {31'd0, e});
      if (k < 10) begin
        pulse();
        check($sformatf("bitcnt_btn%0h_pulse%0d", btn, k + 1), {28'd0, bit_cnt_out},
              (k + 1 > 8) ? 32'd8 : 32'(k + 1));
      end
    end
    check("strobe_single", strobe_cnt - s0, 1);
  endtask

  task automatic turbo_polls(input int exp_zeros, input int exp_trans, input string tag);
    int   zeros;
    int   trans;
    logic prev;
    zeros = 0;
    trans = 0;
    prev  = 1'b0;
    for (int p = 0; p < 6; p++) begin
      jp_latch_in = 1'b1;
      cycles(12);
      jp_latch_in = 1'b0;
      cycles(15);
      if (jp_data_out === 1'b0) zeros++;
      if (p > 0 && jp_data_out !== prev) trans++;
      prev = jp_data_out;
      cycles(3);
    end
    check({tag, "_zeros"}, zeros, exp_zeros);
    check({tag, "_transitions"}, trans, exp_trans);
  endtask

  vec_t vecs[5];

  initial begin
    int s0;
    int zeros;

    vecs[0] = '{btn: 8'h81, exp_line: 8'h7E};
    vecs[1] = '{btn: 8'h00, exp_line: 8'hFF};
    vecs[2] = '{btn: 8'hFF, exp_line: 8'h00};
    vecs[3] = '{btn: 8'hA5, exp_line: 8'h5A};
    vecs[4] = '{btn: 8'h3C, exp_line: 8'hC3};

    nres_in     = 1'b0;
    btn_in      = 8'h00;
    turbo_en_in = 2'b00;
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b0;
    cycles(1);
    check("reset_line", {31'd0, jp_data_out}, 1);
    check("reset_bitcnt", {28'd0, bit_cnt_out}, 0);
    check("reset_strobe", {31'd0, poll_strobe_out}, 0);
    cycles(3);
    nres_in = 1'b1;
    cycles(5);

    for (int v = 0; v < 5; v++) run_vector(vecs[v].btn, vecs[v].exp_line);

    // Sub-filter clock glitch mid-shift
    poll_load(8'hA5);
    for (int i = 0; i < 3; i++) pulse();
    check("glitch_pre_bitcnt", {28'd0, bit_cnt_out}, 3);
    jp_clk_in = 1'b1;
    cycles(2);
    jp_clk_in = 1'b0;
    cycles(20);
    check("glitch_bitcnt", {28'd0, bit_cnt_out}, 3);
    check("glitch_line", {31'd0, jp_data_out}, 1);
    pulse();
    check("glitch_after_bitcnt", {28'd0, bit_cnt_out}, 4);
    check("glitch_after_line", {31'd0, jp_data_out}, 1);

    // Turbo on A: alternating first bit, then 50% duty while latch held
    btn_in      = 8'h01;
    turbo_en_in = 2'b01;
    turbo_polls(3, 5, "turbo_on");
    jp_latch_in = 1'b1;
    cycles(12);
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (jp_data_out === 1'b0) zeros++;
    end
    check("turbo_duty", zeros, 20);
    jp_latch_in = 1'b0;
    cycles(12);
    turbo_en_in = 2'b00;
    turbo_polls(6, 0, "turbo_off");

    // Clock pulses while latch held high
    btn_in      = 8'h01;
    jp_latch_in = 1'b1;
    cycles(12);
    check("hold_line_pressed", {31'd0, jp_data_out}, 0);
    for (int i = 0; i < 3; i++) pulse();
    check("hold_bitcnt", {28'd0, bit_cnt_out}, 0);
    btn_in = 8'h00;
    cycles(2);
    check("hold_tracks_btn", {31'd0, jp_data_out}, 1);
    s0 = strobe_cnt;
    jp_latch_in = 1'b0;
    cycles(12);
    check("hold_release_strobe", strobe_cnt - s0, 1);
    btn_in = 8'h01;
    cycles(5);
    check("shift_ignores_btn", {31'd0, jp_data_out}, 1);

    // Same-cycle latch rise and clock rise: load wins
    pulse();
    pulse();
    check("pre_coincide_bitcnt", {28'd0, bit_cnt_out}, 2);
    jp_latch_in = 1'b1;
    jp_clk_in   = 1'b1;
    cycles(12);
    check("coincide_rise_bitcnt", {28'd0, bit_cnt_out}, 0);
    check("coincide_rise_line", {31'd0, jp_data_out}, 0);
    jp_clk_in = 1'b0;
    cycles(20);
    // Same-cycle latch fall and clock rise: strobe, clock edge dropped
    s0 = strobe_cnt;
    jp_latch_in = 1'b0;
    jp_clk_in   = 1'b1;
    cycles(12);
    check("coincide_fall_strobe", strobe_cnt - s0, 1);
    check("coincide_fall_bitcnt", {28'd0, bit_cnt_out}, 0);
    check("coincide_fall_line", {31'd0, jp_data_out}, 0);
    jp_clk_in = 1'b0;
    cycles(20);
    pulse();
    check("coincide_next_bitcnt", {28'd0, bit_cnt_out}, 1);

    // Asynchronous reset after three shifts, then a clean poll
    poll_load(8'h3C);
    for (int i = 0; i < 3; i++) pulse();
    check("prereset_bitcnt", {28'd0, bit_cnt_out}, 3);
    check("prereset_line", {31'd0, jp_data_out}, 0);
    #2;
    nres_in = 1'b0;
    #1;
    check("async_reset_line", {31'd0, jp_data_out}, 1);
    check("async_reset_bitcnt", {28'd0, bit_cnt_out}, 0);
    check("async_reset_strobe", {31'd0, poll_strobe_out}, 0);
    cycles(3);
    nres_in = 1'b1;
    cycles(5);
    run_vector(8'hC5, 8'h3A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
